// File: rtl/seq_mul_ctrl.sv
// Radix-2 shift-add unsigned multiplier controller that drives an external combinational adder.
// Each BUSY cycle does one add of the multiplicand into the high accumulator and shifts {acc_hi, q} right.
//
// state | meaning
// IDLE  | waiting for an operand pair; in_ready high
// BUSY  | one shift-add iteration per cycle, WIDTH iterations
// DONE  | product presented on out_product until out_ready
module seq_mul_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_cin,
    input  logic [WIDTH-1:0]   add_sum,
    input  logic               add_cout
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] mcand;
    logic [CNT_W-1:0] cnt;

    assign in_ready = (state == IDLE);
    assign add_cin  = 1'b0;
    assign add_a    = (state == BUSY) ? acc_hi : '0;
    assign add_b    = ((state == BUSY) && q[0]) ? mcand : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc_hi      <= '0;
            q           <= '0;
            mcand       <= '0;
            cnt         <= '0;
            out_valid   <= 1'b0;
            out_product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= in_a;
                        q      <= in_b;
                        acc_hi <= '0;
                        cnt    <= '0;
                        // A zero operand makes the product trivially zero; skip the iterations.
                        if ((in_a == '0) || (in_b == '0)) begin
                            out_product <= '0;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc_hi <= {add_cout, add_sum[WIDTH-1:1]};
                    q      <= {add_sum[0], q[WIDTH-1:1]};
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        // Post-shift {acc_hi, q} assembled directly from this cycle's adder result.
                        out_product <= {add_cout, add_sum, q[WIDTH-1:1]};
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_mul_ctrl.md
Name: seq_mul_ctrl

Overview:
- Radix-2 shift-add unsigned multiplier controller; WIDTH x WIDTH operands produce a 2*WIDTH product.
- Sits beside the 16-bit multilevel CLA adder. Each iteration it drives the adder's a/b/cin inputs and consumes its sum/cout.
- The adder stays outside this block and is purely combinational. The add completes within the same cycle.
- Upstream side: valid/ready operand handshake from the execute stage. Downstream side: valid/ready result handshake to writeback.

Parameters:
- WIDTH, 16, operand width; must equal the attached adder width.
- CNT_W, 5, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  multiplicand, unsigned.
- in_b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- out_product  output  2*WIDTH  unsigned product.
- add_a  output  WIDTH  adder operand A.
- add_b  output  WIDTH  adder operand B.
- add_cin  output  1  adder carry-in; always 0.
- add_sum  input  WIDTH  adder sum.
- add_cout  input  1  adder carry-out.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; acc_hi, q, mcand, cnt all 0.
  - out_valid=0, out_product=0.
  - in_ready=1 (decoded from IDLE), add_a=0, add_b=0, add_cin=0.
  - Reset mid-operation discards the operation. No partial product appears on out_product.
- Control and datapath:
  - Three-state FSM: IDLE, BUSY, DONE. in_ready = (state==IDLE), decoded combinationally from state.
  - add_a = acc_hi and add_b = (q[0] ? mcand : 0) only in BUSY; both are 0 in IDLE and DONE.
- IDLE:
  - On an edge where in_valid=1, the block loads mcand<=in_a, q<=in_b, acc_hi<=0, cnt<=0.
  - If in_a==0 or in_b==0, it goes to DONE with out_product<=0 and out_valid<=1 (zero-skip; 1 cycle).
  - Otherwise it goes to BUSY.
- BUSY, each edge:
  - acc_hi <= {add_cout, add_sum[WIDTH-1:1]}.
  - q <= {add_sum[0], q[WIDTH-1:1]}.
  - cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1, the shift still occurs. Then out_product <= {add_cout, add_sum, q[WIDTH-1:1]}, i.e. the post-shift {acc_hi,q}. out_valid<=1, state<=DONE.
  - Latency: out_valid asserts exactly WIDTH cycles after the acceptance edge (16 for the default).
  - in_valid is ignored in BUSY; in_a/in_b may change freely.
- DONE:
  - out_valid=1 and out_product holds stable until the edge where out_ready=1.
  - On that edge: out_valid<=0, state<=IDLE. out_product keeps its last value.
  - in_ready=0 in DONE. The earliest next acceptance is the edge after the handoff, so there is at least one IDLE cycle between operations.
- Width rules:
  - Unsigned only. Max product (2^WIDTH-1)^2 fits in 2*WIDTH bits.
  - add_cout is always captured into the acc_hi MSB, never dropped.
  - No overflow flag.
- cnt counts only in BUSY and is cleared on acceptance.

Test Plan:
- Basic latency: in_a=3, in_b=5, out_ready=1 → out_valid rises 16 cycles after acceptance; out_product=0x0000000F; in_ready low for 17 cycles total.
- Max operands: in_a=0xFFFF, in_b=0xFFFF → out_product=0xFFFE0001. The bench adder model must produce cout=1 on several iterations.
- Zero-skip: in_a=0x1234, in_b=0 → out_valid the cycle after acceptance, out_product=0, add_b stays 0. Repeat with in_a=0, in_b=0xFFFF → same response.
- Backpressure: in_a=0x00FF, in_b=0x0101, out_ready=0 for 10 cycles after out_valid → out_product=0x0000FFFF stable; in_ready=0 throughout; in_valid pulses during the stall are not accepted; IDLE follows the first out_ready=1 edge.
- Reset mid-BUSY: start 0x1234*0x5678, assert rst_n=0 asynchronously at iteration 7 → out_valid=0, out_product=0, in_ready=1 immediately. After release, 0x0002*0x0003 → 0x00000006.
- Back-to-back random: 1000 random pairs with random in_valid/out_ready gaps → every product equals in_a*in_b; ordering is preserved; no acceptance occurs outside IDLE.
